// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single synchronous memory port with fixed read latency MEM_LAT.
// Optional macro MEM_ARB_FIXED_PRIO_EN: port 0 always wins simultaneous requests (default: round-robin).
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_grant, last_grant_nxt;
  logic          win;
  logic          mem_en_nxt, mem_we_nxt, owner_nxt, ack0_nxt, ack1_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt, rdata0_nxt, rdata1_nxt;

  // Port that wins an IDLE-cycle arbitration; only consulted when req0 | req1.
  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    win = ~req0;
`else
    win = (req0 && req1) ? ~last_grant : req1;
`endif
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    mem_en_nxt     = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    owner_nxt      = owner;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    rdata0_nxt     = rdata0;
    rdata1_nxt     = rdata1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt      = ACCESS;
          mem_en_nxt     = 1'b1;
          mem_we_nxt     = win ? we1 : we0;
          mem_addr_nxt   = win ? addr1 : addr0;
          mem_wdata_nxt  = win ? wdata1 : wdata0;
          owner_nxt      = win;
          last_grant_nxt = win;
          cnt_nxt        = CW'(MEM_LAT);
        end
      end
      ACCESS: begin
        // Counter reaches zero on the edge where mem_rdata has been valid for a full cycle.
        if (cnt == '0) begin
          state_nxt = DONE;
          ack0_nxt  = ~owner;
          ack1_nxt  = owner;
          if (owner) rdata1_nxt = mem_rdata;
          else       rdata0_nxt = mem_rdata;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      owner      <= owner_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
      rdata0     <= rdata0_nxt;
      rdata1     <= rdata1_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-port drivers, a latency-accurate memory model, and a monitor
// that checks grants, memory strobes, ack timing and read data against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  parameter int LAT = 1;
  localparam int AW = 8;
  localparam int DW = 16;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic          we;
    logic          noack;
    logic [1:0]    gap;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  initial forever #5 clk = ~clk;

  logic          req_v[2], we_v[2], ack_v[2];
  logic [AW-1:0] addr_v[2];
  logic [DW-1:0] wdata_v[2], rdata_v[2];
  logic          mem_en, mem_we, busy, owner;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req_v[0]), .we0(we_v[0]), .addr0(addr_v[0]), .wdata0(wdata_v[0]),
    .ack0(ack_v[0]), .rdata0(rdata_v[0]),
    .req1(req_v[1]), .we1(we_v[1]), .addr1(addr_v[1]), .wdata1(wdata_v[1]),
    .ack1(ack_v[1]), .rdata1(rdata_v[1]),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // ---------------- shared state ----------------
  cmd_t          cmd_q0[$], cmd_q1[$];
  logic [DW-1:0] exp_q0[$], exp_q1[$];
  logic [DW-1:0] init_val[256];
  logic [DW-1:0] ref_mem[256];
  logic          grant_log[$];
  int            n_pass = 0;
  int            n_total = 0;
  logic          s_req0, s_req1, s_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [1:0] gap, input logic noack);
    cmd_t c;
    c.we = we; c.addr = a; c.data = d; c.gap = gap; c.noack = noack;
    return c;
  endfunction

  // ---------------- memory model: read-first, data valid LAT cycles after mem_en is registered ----
  logic [DW-1:0] mem[256];
  logic          written[256];
  logic [DW-1:0] pipe[LAT];
  assign mem_rdata = pipe[LAT-1];

  initial begin
    for (int i = 0; i < 256; i++) written[i] <= 1'b0;
    for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        pipe[0] <= written[mem_addr] ? mem[mem_addr] : init_val[mem_addr];
        if (mem_we) begin
          mem[mem_addr]     <= mem_wdata;
          written[mem_addr] <= 1'b1;
        end
      end
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Request lines and reset as seen by the DUT at each rising edge.
  initial forever begin
    @(posedge clk);
    s_req0 = req_v[0];
    s_req1 = req_v[1];
    s_rst  = reset;
  end

  // ---------------- drivers ----------------
  task automatic run_port(input int p);
    cmd_t          c;
    int            t;
    logic [DW-1:0] e;
    req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0;
    forever begin
      @(negedge clk);
      if ((p == 0 && cmd_q0.size() == 0) || (p == 1 && cmd_q1.size() == 0)) begin
        req_v[p] = 1'b0;
        continue;
      end
      c = (p == 0) ? cmd_q0.pop_front() : cmd_q1.pop_front();
      if (!c.noack) begin
        // Serialised, read-first memory: ack data is the contents before this access.
        e = ref_mem[c.addr];
        if (c.we) ref_mem[c.addr] = c.data;
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
      if (c.gap != 0) begin
        req_v[p] = 1'b0;
        repeat (c.gap) @(negedge clk);
      end
      we_v[p] = c.we; addr_v[p] = c.addr; wdata_v[p] = c.data; req_v[p] = 1'b1;
      if (c.noack) begin
        t = 0;
        while (!reset && t < 20) begin @(negedge clk); t++; end
        chk("abort_reset_seen", 32'(reset), 1);
        req_v[p] = 1'b0;
      end else begin
        t = 0;
        do begin @(negedge clk); t++; end while (!ack_v[p] && t < 40);
        chk($sformatf("ack%0d_timeout", p), 32'(ack_v[p]), 1);
      end
    end
  endtask

  initial run_port(0);
  initial run_port(1);

  // ---------------- monitor / scoreboard ----------------
  logic          in_flight, tb_last, eo;
  int            lat;
  logic [DW-1:0] last_rd[2];
  logic [DW-1:0] mon_e;

  initial forever begin
    @(negedge clk);
    if (s_rst) begin
      chk("reset_ctl", 32'({ack_v[0], ack_v[1], mem_en, mem_we, busy, owner, mem_addr}), 0);
      chk("reset_rdata", {rdata_v[0], rdata_v[1]}, 0);
      chk("reset_wdata", 32'(mem_wdata), 0);
      in_flight = 1'b0; lat = 0; tb_last = 1'b1;
      last_rd[0] = '0; last_rd[1] = '0;
    end else begin
      if (mem_en) begin
        eo = (s_req0 && s_req1) ? (FIXED ? 1'b0 : ~tb_last) : s_req1;
        chk("grant_has_req", 32'(s_req0 | s_req1), 1);
        chk("grant_while_busy", 32'(in_flight), 0);
        chk("owner", 32'(owner), 32'(eo));
        chk("mem_addr", 32'(mem_addr), 32'(addr_v[eo]));
        chk("mem_we", 32'(mem_we), 32'(we_v[eo]));
        if (we_v[eo]) chk("mem_wdata", 32'(mem_wdata), 32'(wdata_v[eo]));
        grant_log.push_back(owner);
        tb_last = eo; in_flight = 1'b1; lat = 0;
      end else begin
        chk("mem_we_pulse", 32'(mem_we), 0);
        if (in_flight) lat++;
      end
      chk("busy", 32'(busy), 32'(in_flight));
      for (int p = 0; p < 2; p++) begin
        if (ack_v[p]) begin
          chk("ack_in_flight", 32'(in_flight), 1);
          chk("ack_port", p, 32'(tb_last));
          chk("ack_latency", lat, LAT + 1);
          if ((p == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            chk("ack_unexpected", 32'(ack_v[p]), 0);
          end else begin
            mon_e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("rdata%0d", p), 32'(rdata_v[p]), 32'(mon_e));
            last_rd[p] = mon_e;
          end
        end else begin
          chk($sformatf("rdata%0d_hold", p), 32'(rdata_v[p]), 32'(last_rd[p]));
        end
      end
      if (ack_v[0] || ack_v[1]) in_flight = 1'b0;
    end
  end

  // ---------------- main sequence ----------------
  task automatic wait_idle(input int budget);
    int t = 0;
    do begin @(negedge clk); t++; end
    while (!(cmd_q0.size() == 0 && cmd_q1.size() == 0 && exp_q0.size() == 0 &&
             exp_q1.size() == 0 && !req_v[0] && !req_v[1] && !busy) && t < budget);
    chk("drain", cmd_q0.size() + cmd_q1.size() + exp_q0.size() + exp_q1.size(), 0);
    @(posedge clk);
  endtask

  initial begin
    int   n0, t;
    logic exp_order[4];
    for (int i = 0; i < 256; i++) begin
      init_val[i] = 16'($urandom);
      ref_mem[i]  = init_val[i];
    end
    init_val[8'h12] = 16'hBEEF; ref_mem[8'h12] = 16'hBEEF;
    init_val[8'h20] = 16'h00A5; ref_mem[8'h20] = 16'h00A5;

    // Port-0 read held through reset: no strobe until reset is released.
    cmd_q0.push_back(mk(1'b0, 8'h12, '0, 2'd0, 1'b0));
    repeat (4) @(negedge clk);
    reset = 1'b0;
    wait_idle(100);

    cmd_q0.push_back(mk(1'b0, 8'h20, '0, 2'd0, 1'b0));
    wait_idle(100);

    // Port-1 write then read-back.
    cmd_q1.push_back(mk(1'b1, 8'h05, 16'h1234, 2'd0, 1'b0));
    cmd_q1.push_back(mk(1'b0, 8'h05, '0, 2'd1, 1'b0));
    wait_idle(100);

    // Both ports request continuously; previous grant was port 1.
    n0 = grant_log.size();
    cmd_q0.push_back(mk(1'b0, 8'h30, '0, 2'd0, 1'b0));
    cmd_q0.push_back(mk(1'b1, 8'h31, 16'h5A5A, 2'd0, 1'b0));
    cmd_q1.push_back(mk(1'b1, 8'hB0, 16'hC3C3, 2'd0, 1'b0));
    cmd_q1.push_back(mk(1'b0, 8'hB0, '0, 2'd0, 1'b0));
    wait_idle(200);
    if (FIXED) begin
      exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b1;
    end else begin
      exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
    end
    chk("rr_count", grant_log.size() - n0, 4);
    for (int i = 0; i < 4 && n0 + i < grant_log.size(); i++)
      chk($sformatf("rr_order_%0d", i), 32'(grant_log[n0+i]), 32'(exp_order[i]));

    // Reset in the cycle after the grant edge aborts the access without an ack.
    cmd_q1.push_back(mk(1'b0, 8'h40, '0, 2'd0, 1'b1));
    t = 0;
    while (!mem_en && t < 50) begin @(negedge clk); t++; end
    chk("abort_grant_seen", 32'(mem_en), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_idle(100);
    cmd_q1.push_back(mk(1'b0, 8'h07, '0, 2'd0, 1'b0));
    wait_idle(100);

    // Randomised traffic on disjoint address halves.
    for (int k = 0; k < 30; k++) begin
      cmd_q0.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)),
                          16'($urandom), 2'($urandom_range(0, 3)), 1'b0));
      cmd_q1.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)),
                          16'($urandom), 2'($urandom_range(0, 3)), 1'b0));
    end
    wait_idle(4000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the processor's single synchronous memory port between two requesters: port 0 (CPU fetch/data) and port 1 (testbench loader / debug DMA).
- Serialises accesses, arbitrates simultaneous requests round-robin, sequences the memory's fixed read latency and returns a one-cycle ack with read data.
- Sits between the CPU/loader and the memory block.

Parameters:
- AW, 8, address width.
- DW, 16, data width.
- MEM_LAT, 1, cycles from the memory registering mem_en to mem_rdata being valid; legal values are 1 or more.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port-0 request; held until ack0.
- we0  in  1  port-0 write enable; 1 = write, 0 = read.
- addr0  in  AW  port-0 address.
- wdata0  in  DW  port-0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  DW  port-0 read data; valid while ack0 is high.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high while an access is in flight.
- owner  out  1  index of the granted port; meaningful only while busy=1.

Behaviour:
- Reset (synchronous): state=IDLE. All outputs 0, including ack*, rdata*, mem_* and busy. Counter=0. last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples req0/req1 at each edge.
  - Neither high: stay in IDLE.
  - One high: grant that port.
  - Both high: grant the port != last_grant.
  - At the grant edge (E0): capture the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata; set mem_en=1, owner, last_grant=winner, counter=MEM_LAT; go to ACCESS.
- ACCESS:
  - mem_en is high only during cycle [E0,E1); mem_we follows the same pulse. mem_addr/mem_wdata hold until the next grant.
  - Counter decrements at each edge from E1 onward.
  - At edge E(1+MEM_LAT): capture mem_rdata into rdata[owner], assert ack[owner], go to DONE.
- DONE:
  - ack[owner] is high for exactly one cycle [E(1+MEM_LAT), E(2+MEM_LAT)). Return to IDLE.
  - req inputs are ignored in DONE.
- Total latency: ack arrives MEM_LAT+1 cycles after the grant edge; 2 cycles at default.
- Writes use the same timing as reads. rdata is still loaded from mem_rdata and must be ignored by the requester.
- rdataN holds its last value until the next ack on that port.
- Requester protocol: drop req (or present a new request) no earlier than the cycle after ack. The IDLE cycle after DONE re-samples the req lines. Peak throughput is therefore one access per MEM_LAT+3 cycles.
- busy=1 in ACCESS and DONE; busy=0 in IDLE.
- A request dropped mid-access is a protocol violation. The access still completes and acks.
- addr/we/wdata changes after the grant edge have no effect.
- Reset during ACCESS or DONE: abort immediately to the reset state. No ack is issued, and last_grant returns to 1.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: on a simultaneous request, port 0 always wins. last_grant is still updated but ignored.
- Undefined (default): round-robin as above.
- Single-request behaviour is identical in both builds.

Test Plan:
- Reset check: after reset, all outputs are 0 and busy=0. Holding req0=1 during reset produces no mem_en until the first edge with reset=0.
- Port-0 read: req0=1, addr0=0x12, model returns 0xBEEF, MEM_LAT=1.
  - Expect mem_en=1 with mem_we=0 and mem_addr=0x12 for exactly one cycle.
  - Expect ack0=1 and rdata0=0xBEEF two cycles after the grant edge.
  - ack1 stays 0.
- Port-1 write: req1=1, we1=1, addr1=0x05, wdata1=0x1234.
  - Expect a single cycle with mem_en=mem_we=1, mem_addr=0x05, mem_wdata=0x1234.
  - Expect one ack1 pulse, then memory location 0x05 reads back 0x1234.
- Round-robin: both requesters hold requests continuously, re-requesting after each ack, for 4 accesses.
  - Default build: grant order 0,1,0,1; each ack is a single-cycle pulse; busy never drops mid-access.
  - MEM_ARB_FIXED_PRIO_EN build: grant order 0,0,0,0.
- Reset mid-access: assert reset in the cycle after the grant edge.
  - Expect no ack, state IDLE, outputs 0.
  - A following req1 read of 0x07 completes normally with latency 2.
- Latency sweep with MEM_LAT=3: a read of 0x20 returning 0x00A5 acks exactly 4 cycles after the grant edge with rdata=0x00A5.
